// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one 16-bit memory port between the CPU bus and the
//             video fetcher; video has priority, bounded by a run-length guard.
//  Revision : 1.0  initial release
// ============================================================================

module mem_arbiter #(
    parameter int LATENCY     = 2,
    parameter int MAX_VID_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,

    input  logic        vid_req,
    input  logic [19:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,

    output logic [19:0] m_addr,
    output logic [15:0] m_wdata,
    output logic [1:0]  m_be,
    output logic        m_we,
    input  logic [15:0] m_rdata,

    output logic        grant_vid,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] C_LAT_LAST = 4'(LATENCY - 1);
    localparam logic [3:0] C_MAX_RUN  = 4'(MAX_VID_RUN);

    logic [1:0]  state_q,     state_d;
    logic [3:0]  lat_cnt_q,   lat_cnt_d;
    logic [3:0]  vid_run_q,   vid_run_d;
    logic        cur_vid_q,   cur_vid_d;
    logic        cur_we_q,    cur_we_d;
    logic [19:0] m_addr_q,    m_addr_d;
    logic [15:0] m_wdata_q,   m_wdata_d;
    logic [1:0]  m_be_q,      m_be_d;
    logic        cpu_ack_q,   cpu_ack_d;
    logic        vid_ack_q,   vid_ack_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] vid_rdata_q, vid_rdata_d;

    logic        pick_vid;

    // Address bit 0 is a byte offset inside the word and is never used.
    logic        unused_addr_bits;
    assign unused_addr_bits = cpu_addr[0] ^ vid_addr[0];

    // CPU is forced through only once video has used its full run budget.
    assign pick_vid = vid_req && !(cpu_req && (vid_run_q >= C_MAX_RUN));

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        vid_run_d   = vid_run_q;
        cur_vid_d   = cur_vid_q;
        cur_we_d    = cur_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_be_d      = m_be_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (vid_req || cpu_req) begin
                    state_d   = S_ACCESS;
                    lat_cnt_d = 4'd0;
                    cur_vid_d = pick_vid;
                    if (pick_vid) begin
                        cur_we_d = 1'b0;
                        m_addr_d = {vid_addr[19:1], 1'b0};
                        m_be_d   = 2'b11;
                        if (cpu_req) begin
                            vid_run_d = (vid_run_q >= C_MAX_RUN) ? C_MAX_RUN
                                                                 : vid_run_q + 4'd1;
                        end else begin
                            vid_run_d = 4'd0;
                        end
                    end else begin
                        cur_we_d  = cpu_we;
                        m_addr_d  = {cpu_addr[19:1], 1'b0};
                        m_be_d    = cpu_be;
                        m_wdata_d = cpu_wdata;
                        vid_run_d = 4'd0;
                    end
                end
            end

            S_ACCESS: begin
                if (lat_cnt_q == C_LAT_LAST) begin
                    state_d = S_DONE;
                    if (cur_vid_q) begin
                        vid_ack_d   = 1'b1;
                        vid_rdata_d = m_rdata;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!cur_we_q) begin
                            cpu_rdata_d = m_rdata;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= 4'd0;
            vid_run_q   <= 4'd0;
            cur_vid_q   <= 1'b0;
            cur_we_q    <= 1'b0;
            m_addr_q    <= 20'd0;
            m_wdata_q   <= 16'd0;
            m_be_q      <= 2'b00;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= 16'd0;
            vid_rdata_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            vid_run_q   <= vid_run_d;
            cur_vid_q   <= cur_vid_d;
            cur_we_q    <= cur_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_be_q      <= m_be_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    // Write strobe is decoded from state so reset removes it without a clock.
    assign m_we      = (state_q == S_ACCESS) && cur_we_q;
    assign busy      = (state_q != S_IDLE);
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign grant_vid = cur_vid_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter (LATENCY 2 and 1).
//  Revision : 1.0  initial release
// ============================================================================

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance A: LATENCY=2, MAX_VID_RUN=4
    logic        cpu_req = 0, cpu_we = 0, vid_req = 0;
    logic [19:0] cpu_addr = 0, vid_addr = 0;
    logic [1:0]  cpu_be = 2'b11;
    logic [15:0] cpu_wdata = 0;
    logic        cpu_ack, vid_ack, m_we, grant_vid, busy;
    logic [15:0] cpu_rdata, vid_rdata, m_wdata, m_rdata;
    logic [19:0] m_addr;
    logic [1:0]  m_be;

    // Instance B: LATENCY=1
    logic        cpu_req1 = 0, vid_req1 = 0;
    logic [19:0] cpu_addr1 = 0;
    logic        cpu_ack1, vid_ack1, m_we1, grant_vid1, busy1;
    logic [15:0] cpu_rdata1, vid_rdata1, m_wdata1, m_rdata1;
    logic [19:0] m_addr1;
    logic [1:0]  m_be1;

    logic [15:0] mem  [0:1023];
    logic [15:0] mem1 [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    logic [15:0] cpu_q[$], vid_q[$], cpu_q1[$];
    logic        order_q[$];
    logic        log_en = 0;
    logic [3:0]  run_max = 0;

    mem_arbiter #(.LATENCY(2), .MAX_VID_RUN(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_we(m_we), .m_rdata(m_rdata),
        .grant_vid(grant_vid), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1), .MAX_VID_RUN(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_be(2'b11),
        .cpu_wdata(16'h0000), .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .vid_req(vid_req1), .vid_addr(20'h00000), .vid_ack(vid_ack1), .vid_rdata(vid_rdata1),
        .m_addr(m_addr1), .m_wdata(m_wdata1), .m_be(m_be1), .m_we(m_we1), .m_rdata(m_rdata1),
        .grant_vid(grant_vid1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Combinational word memories with byte-enabled writes.
    assign m_rdata  = mem[m_addr[10:1]];
    assign m_rdata1 = mem1[m_addr1[10:1]];

    always @(posedge clk) begin
        if (m_we) begin
            if (m_be[0]) mem[m_addr[10:1]][7:0]  <= m_wdata[7:0];
            if (m_be[1]) mem[m_addr[10:1]][15:8] <= m_wdata[15:8];
        end
        if (m_we1) begin
            if (m_be1[0]) mem1[m_addr1[10:1]][7:0]  <= m_wdata1[7:0];
            if (m_be1[1]) mem1[m_addr1[10:1]][15:8] <= m_wdata1[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ack pops the next expected read word for its port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ack) begin
                if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 1, 0);
                else                   chk("cpu_rdata_sb", {16'h0, cpu_rdata}, {16'h0, cpu_q.pop_front()});
                if (log_en) order_q.push_back(1'b0);
            end
            if (vid_ack) begin
                if (vid_q.size() == 0) chk("vid_ack_unexpected", 1, 0);
                else                   chk("vid_rdata_sb", {16'h0, vid_rdata}, {16'h0, vid_q.pop_front()});
                if (log_en) order_q.push_back(1'b1);
            end
            if (cpu_ack1) begin
                if (cpu_q1.size() == 0) chk("cpu1_ack_unexpected", 1, 0);
                else                    chk("cpu1_rdata_sb", {16'h0, cpu_rdata1}, {16'h0, cpu_q1.pop_front()});
            end
            if (vid_ack1) chk("vid1_ack_unexpected", 1, 0);
            if (log_en && u_dut.vid_run_q > run_max) run_max <= u_dut.vid_run_q;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        int          nack;
        int          prev_ack;
        logic [9:0]  ord;

        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 16'(i * 3);
            mem1[i] = 16'(i * 5);
        end
        mem[10'h092]  = 16'hBEEF;
        mem[10'h100]  = 16'h5566;
        mem[10'h180]  = 16'hA5A5;
        mem[10'h181]  = 16'h5A5A;
        mem[10'h200]  = 16'h1111;
        mem[10'h000]  = 16'h0F0F;
        mem1[10'h008] = 16'h1001;
        mem1[10'h009] = 16'h2002;
        mem1[10'h00A] = 16'h3003;

        // Reset state
        cyc(); cyc();
        chk("rst_ctl", {5'b0, m_addr, m_be, cpu_ack, vid_ack, m_we, grant_vid, busy}, 32'h0);
        chk("rst_rdata", {cpu_rdata, vid_rdata}, 32'h0);
        chk("rst_wdata", {16'h0, m_wdata}, 32'h0);
        rst_n = 1'b1;

        // CPU read of an odd byte address
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00125; cpu_be = 2'b11; cpu_wdata = 16'h0000;
        cpu_q.push_back(16'hBEEF);
        for (int c = 1; c <= 2; c++) begin
            cyc();
            chk("rd_m_addr", {12'h0, m_addr}, 32'h00124);
            chk("rd_m_we_busy_ack", {m_we, busy, cpu_ack}, 3'b010);
        end
        cyc();
        chk("rd_ack_c3", {cpu_ack, busy}, 2'b11);
        chk("rd_rdata", {16'h0, cpu_rdata}, 32'hBEEF);
        cpu_req = 0;
        cyc();
        chk("rd_idle_c4", {cpu_ack, busy}, 2'b00);

        // CPU high-byte write
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00201; cpu_be = 2'b10; cpu_wdata = 16'h12AB;
        cpu_q.push_back(16'hBEEF);
        for (int c = 1; c <= 2; c++) begin
            cyc();
            chk("wr_port", {m_addr, m_be, m_we}, {20'h00200, 2'b10, 1'b1});
            chk("wr_wdata", {16'h0, m_wdata}, 32'h12AB);
        end
        cyc();
        chk("wr_ack_c3", {cpu_ack, m_we}, 2'b10);
        cpu_req = 0;
        cyc();
        chk("wr_mem", {16'h0, mem[10'h100]}, 32'h1266);

        // Simultaneous requests: video first, then CPU
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00302; cpu_be = 2'b11;
        vid_req = 1; vid_addr = 20'h00301;
        vid_q.push_back(16'hA5A5);
        cpu_q.push_back(16'h5A5A);
        cyc();
        chk("both_c1_port", {m_addr, m_be, m_we, grant_vid}, {20'h00300, 2'b11, 1'b0, 1'b1});
        chk("both_c1_wdata_held", {16'h0, m_wdata}, 32'h12AB);
        cyc(); cyc();
        chk("both_c3", {vid_ack, cpu_ack, grant_vid}, 3'b101);
        vid_req = 0;
        cyc();
        chk("both_c4_idle", {busy, grant_vid}, 2'b01);
        cyc();
        chk("both_c5_cpu", {m_addr, grant_vid}, {20'h00302, 1'b0});
        cyc();
        chk("both_c6", {12'h0, cpu_ack}, 0);
        cyc();
        chk("both_c7", {cpu_ack, vid_ack, grant_vid}, 3'b100);
        cpu_req = 0;
        cyc();

        // Starvation guard: both requesters continuously busy
        for (int k = 0; k < 8; k++) vid_q.push_back(16'hA5A5);
        cpu_q.push_back(16'h5A5A);
        cpu_q.push_back(16'h5A5A);
        log_en = 1; run_max = 0;
        cpu_req = 1; vid_req = 1; vid_addr = 20'h00300;
        nack = 0;
        for (int c = 0; c < 200 && nack < 10; c++) begin
            cyc();
            if (cpu_ack || vid_ack) nack++;
        end
        cpu_req = 0; vid_req = 0;
        chk("starve_ack_count", nack, 10);
        cyc(); cyc();
        log_en = 0;
        chk("starve_log_size", order_q.size(), 10);
        ord = '0;
        for (int k = 0; k < 10 && k < order_q.size(); k++) ord[9-k] = order_q[k];
        chk("starve_order", {22'h0, ord}, {22'h0, 10'b1111011110});
        chk("starve_run_max", {28'h0, run_max}, 32'd4);

        // Asynchronous reset in the middle of a CPU write
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00400; cpu_be = 2'b11; cpu_wdata = 16'h7777;
        cyc();
        chk("rstmid_we_before", {31'h0, m_we}, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rstmid_we_async", {31'h0, m_we}, 0);
        chk("rstmid_ctl", {5'b0, m_addr, m_be, cpu_ack, vid_ack, m_we, grant_vid, busy}, 32'h0);
        chk("rstmid_rdata", {cpu_rdata, vid_rdata}, 32'h0);
        chk("rstmid_wdata", {16'h0, m_wdata}, 32'h0);
        cpu_req = 0;
        cyc(); cyc();
        chk("rstmid_no_ack", {30'h0, cpu_ack, busy}, 0);
        chk("rstmid_mem", {16'h0, mem[10'h200]}, 32'h1111);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00000;
        cpu_q.push_back(16'h0F0F);
        rst_n = 1;
        cyc();
        chk("post_rst_c1", {31'h0, cpu_ack}, 0);
        cyc();
        chk("post_rst_c2", {31'h0, cpu_ack}, 0);
        cyc();
        chk("post_rst_c3", {31'h0, cpu_ack}, 1);
        chk("post_rst_rdata", {16'h0, cpu_rdata}, 32'h0F0F);
        cpu_req = 0;
        cyc();

        // LATENCY=1 back-to-back reads
        prev_ack = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_req1 = 1;
            cpu_addr1 = 20'(20'h00010 + 2 * i);
            cpu_q1.push_back(mem1[10'h008 + i]);
            t = 0;
            do begin
                cyc();
                t++;
            end while (!cpu_ack1 && t < 10);
            chk("l1_ack_latency", t, 2);
            chk("l1_rdata", {16'h0, cpu_rdata1}, {16'h0, mem1[10'h008 + i]});
            if (i > 0) chk("l1_ack_spacing", cyc_cnt - prev_ack, 3);
            prev_ack = cyc_cnt;
            cpu_req1 = 0;
            cyc();
        end

        cyc(); cyc();
        chk("sb_drained", cpu_q.size() + vid_q.size() + cpu_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 16-bit word memory port between the x8086 CPU bus and the video scan-out fetcher. It runs in the memory clock domain, serialises accesses with a fixed-latency access cycle, and gives each requester a req/ack handshake. Video has priority, and a run-length guard prevents CPU starvation.

## Interface
- LATENCY, 2, memory read latency in cycles, from the first cycle m_addr is presented to the cycle m_rdata is valid inclusive; legal 1..15.
- MAX_VID_RUN, 4, maximum number of consecutive video grants while cpu_req is pending; legal 1..15.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request; held with all cpu_* fields stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  20  byte address; bit 0 ignored (word access).
- cpu_be  in  2  byte enables; [1] = high byte (odd address), [0] = low byte.
- cpu_wdata  in  16  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data, valid with cpu_ack, held until the next CPU read completes.
- vid_req  in  1  video read request; same hold rule.
- vid_addr  in  20  byte address; bit 0 ignored.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  16  read data, valid with vid_ack, held until the next video read completes.
- m_addr  out  20  memory word address, bit 0 always 0.
- m_wdata  out  16  memory write data.
- m_be  out  2  memory byte enables.
- m_we  out  1  memory write strobe.
- m_rdata  in  16  memory read data.
- grant_vid  out  1  1 while the current or last access belongs to video.
- busy  out  1  1 in ACCESS and DONE.

## Operation
- States:
  - IDLE: sample requests.
  - ACCESS: lasts exactly LATENCY cycles.
  - DONE: one cycle, ack asserted.
  - Return to IDLE.
- IDLE arbitration:
  - Only vid_req high: video wins.
  - Only cpu_req high: CPU wins.
  - Both high: video wins unless vid_run == MAX_VID_RUN, in which case CPU wins.
  - Neither high: stay in IDLE.
- vid_run (4-bit counter):
  - +1 on a video grant while cpu_req is high.
  - Cleared on a CPU grant, or on a video grant while cpu_req is low.
  - Saturates at MAX_VID_RUN.
- On grant, register into the memory port:
  - m_addr = {addr[19:1],1'b0}.
  - m_be = cpu_be for CPU, 2'b11 for video.
  - m_wdata = cpu_wdata for CPU, unchanged for video.
  - grant_vid set.
- m_we = 1 for all LATENCY cycles of a CPU write's ACCESS; 0 at every other time.
- Reads: at the clock edge that ends the last ACCESS cycle, m_rdata is captured into the winner's rdata register and the winner's ack is set.
- Writes: ack is set at the same edge; cpu_rdata is unchanged.
- DONE: requests are ignored. The requester drops or changes req on the edge where it sees ack. The next arbitration happens in the following IDLE cycle.
- m_addr, m_be, m_wdata and grant_vid hold their values after an access completes; they change only on the next grant.

## Timing
- Request first seen in IDLE cycle N:
  - m_* valid in cycles N+1 .. N+LATENCY.
  - Ack high in cycle N+LATENCY+1.
  - Back in IDLE at N+LATENCY+2.
- Best-case throughput: one access per LATENCY+2 cycles.
- A request that loses arbitration waits in IDLE for the other access to complete; it is re-arbitrated at the next IDLE cycle.
- Reset (asynchronous, takes effect immediately, including mid-access):
  - All outputs 0: cpu_ack, vid_ack, cpu_rdata, vid_rdata, m_addr, m_wdata, m_be, m_we, grant_vid, busy.
  - vid_run = 0, state = IDLE.
  - The in-flight access is aborted with no ack.
- After rst_n rises: first arbitration at the first rising edge.
- A request asserted during ACCESS or DONE is not lost; it is served from IDLE.

## Test plan
- CPU read, LATENCY=2. Memory word at 0x00124 = 0xBEEF; cpu_req in cycle 0 with addr 0x00125, we=0 -> m_addr=0x00124 in cycles 1–2, m_we=0, cpu_ack only in cycle 3, cpu_rdata=0xBEEF, busy high in cycles 1–3.
- CPU write, LATENCY=2. addr 0x00201, be=2'b10, wdata=0x12AB -> m_addr=0x00200, m_be=2'b10, m_we=1 exactly in cycles 1–2, cpu_ack in cycle 3. Memory byte 0x201 = 0x12; byte 0x200 unchanged; cpu_rdata unchanged.
- Both requests in IDLE cycle 0, LATENCY=2 -> vid_ack in cycle 3, grant_vid=1; CPU granted in cycle 4, cpu_ack in cycle 7, grant_vid=0.
- Starvation guard, MAX_VID_RUN=4. vid_req and cpu_req held, each re-asserted right after its ack -> grant order V,V,V,V,C,V,V,V,V,C; vid_run never exceeds 4.
- Reset during the ACCESS cycle of a CPU write -> m_we falls without waiting for a clock edge; no cpu_ack; all outputs 0. After release, a fresh CPU read to 0x00000 completes with ack in cycle LATENCY+1.
- LATENCY=1 back-to-back CPU reads, req re-asserted the cycle after each ack -> acks spaced exactly 3 cycles apart, each returning the addressed word.
